// File: rtl/riscv_mem_pkg.sv
// Shared load/store definitions for the data-memory responder: funct3 codes,
// FSM states, and the captured request record.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } dmem_req_t;

  // Stores only come in B/H/W; loads add the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a right-aligned core datum and a 32-bit RAM word:
// write strobes, replicated write data, extended load data and alignment check.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]                           funct3_i,
  input  logic [1:0]                           addr_lo_i,
  input  logic [31:0]                          wdata_i,
  input  logic [31:0]                          rword_i,
  output logic [NUM_LANES-1:0]                 be_o,
  output logic [NUM_LANES-1:0][VEC_W-1:0]      wword_o,
  output logic [31:0]                          ldata_o,
  output logic                                 misalign_o
);

  logic [1:0]  sz;
  logic        sgn;
  logic [31:0] shifted;

  assign sz      = funct3_i[1:0];
  assign sgn     = ~funct3_i[2];
  assign shifted = rword_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o       = 4'hF;
    misalign_o = 1'b0;
    ldata_o    = rword_i;
    case (sz)
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        ldata_o = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        misalign_o = addr_lo_i[0];
        ldata_o    = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      default: misalign_o = |addr_lo_i;
    endcase
  end

  // Replicate the datum across every lane; the strobes pick the live ones.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_comb begin
      case (sz)
        2'b00:   wword_o[l] = wdata_i[7:0];
        2'b01:   wword_o[l] = wdata_i[(l % 2)*VEC_W +: VEC_W];
        default: wword_o[l] = wdata_i[l*VEC_W +: VEC_W];
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store front end with programmable
// wait states, RV32I sub-word access and fault reporting over a word RAM.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0]   ADDR_LIM = 32'(4 * DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dmem_req_t   req_q, req_in, eff;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        enter_resp;

  logic [31:0] mem [DEPTH_WORDS];

  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0][VEC_W-1:0] wword;
  logic [31:0] rword, ldata;
  logic [AW-1:0] widx;
  logic        misalign, oor, err;

  assign req_in = '{addr: req_addr, we: req_we, funct3: req_funct3, wdata: req_wdata};
  // With no wait states the access resolves on the accepting edge, so look at the live request.
  assign eff    = (state_q == IDLE) ? req_in : req_q;
  assign widx   = eff.addr[AW+1:2];
  assign rword  = mem[widx];
  assign oor    = eff.addr >= ADDR_LIM;
  assign err    = misalign | oor | ~f3_legal(eff.we, eff.funct3);

  dmem_lane_align u_align (
    .funct3_i   (eff.funct3),
    .addr_lo_i  (eff.addr[1:0]),
    .wdata_i    (eff.wdata),
    .rword_i    (rword),
    .be_o       (be),
    .wword_o    (wword),
    .ldata_o    (ldata),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == '0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) req_q <= req_in;
      if (enter_resp) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || eff.we) ? 32'h0 : ldata;
      end
    end
  end

  // RAM is not reset; a faulting store never reaches it.
  always_ff @(posedge clk) begin
    if (enter_resp && eff.we && !err) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem[widx][l*VEC_W +: VEC_W] <= wword[l];
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (no wait states / one wait
// state) checked against a byte-array reference of RV32I load/store rules.
module tb_dmem_responder;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        req_valid [2], req_ready [2], req_we [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid [2], rsp_ready [2], rsp_err [2];

  int checks = 0;
  int failures = 0;
  logic [7:0] mem_m [2][4*DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_we(req_we[0]), .req_funct3(req_funct3[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_we(req_we[1]), .req_funct3(req_funct3[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference: size from funct3, natural alignment, range, legality.
  function automatic void model(input int i, input logic [31:0] a, input logic we,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    logic legal;
    int sz;
    logic [31:0] v;
    legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz  = 1 << f3[1:0];
    rd  = 32'h0;
    err = !legal || (a % sz != 0) || (a >= 4*DEPTH);
    if (err) return;
    if (we) begin
      for (int k = 0; k < sz; k++) mem_m[i][a+k] = wd[8*k +: 8];
    end else begin
      v = 32'h0;
      for (int k = 0; k < sz; k++) v = v | (32'(mem_m[i][a+k]) << (8*k));
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      rd = v;
    end
  endfunction

  task automatic txn(input int i, input logic [31:0] a, input logic we, input logic [2:0] f3,
                     input logic [31:0] wd, input int bp, input bit early, output logic [31:0] rd);
    logic [31:0] exp_rd, hold_rd;
    logic        exp_err, hold_err;
    int lat;
    model(i, a, we, f3, wd, exp_rd, exp_err);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1; req_addr[i] = a; req_we[i] = we;
    req_funct3[i] = f3; req_wdata[i] = wd; rsp_ready[i] = early;
    @(posedge clk); #1;
    req_valid[i] = 1'b0; req_addr[i] = $urandom; req_wdata[i] = $urandom;
    req_we[i] = 1'($urandom); req_funct3[i] = 3'($urandom);
    lat = 1;
    while (!rsp_valid[i] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(1 + i));
    chk("rsp_rdata", rsp_rdata[i], exp_rd);
    chk("rsp_err", 32'(rsp_err[i]), 32'(exp_err));
    hold_rd = rsp_rdata[i];
    hold_err = rsp_err[i];
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid[i]), 32'd1);
      chk("bp_rdata", rsp_rdata[i], hold_rd);
      chk("bp_err", 32'(rsp_err[i]), 32'(hold_err));
      chk("bp_req_ready", 32'(req_ready[i]), 32'd0);
    end
    @(negedge clk);
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    chk("rsp_consumed", 32'(rsp_valid[i]), 32'd0);
    chk("back_to_idle", 32'(req_ready[i]), 32'd1);
    rsp_ready[i] = 1'b0;
    rd = hold_rd;
  endtask

  task automatic chk_reset(input int i);
    chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
    chk("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic [2:0] f3;
    int i, bp;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_addr[k] = '0; req_we[k] = 1'b0;
      req_funct3[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) chk_reset(k);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < DEPTH; w++) txn(k, 32'(w*4), 1'b1, F3_W, $urandom, 0, 1'b0, rd);

    txn(1, 32'h10, 1'b1, F3_W, 32'hDEADBEEF, 0, 1'b0, rd);
    txn(1, 32'h10, 1'b0, F3_W, 32'h0, 0, 1'b0, rd);  chk("lw_beef", rd, 32'hDEADBEEF);
    txn(1, 32'h11, 1'b1, F3_B, 32'hAAAAAA7F, 0, 1'b0, rd);
    txn(1, 32'h10, 1'b0, F3_W, 32'h0, 0, 1'b0, rd);  chk("lw_after_sb", rd, 32'hDEAD7FEF);
    txn(1, 32'h13, 1'b0, F3_B, 32'h0, 0, 1'b0, rd);  chk("lb_sext", rd, 32'hFFFFFFDE);
    txn(1, 32'h13, 1'b0, F3_BU, 32'h0, 0, 1'b0, rd); chk("lbu_zext", rd, 32'h000000DE);
    txn(1, 32'h22, 1'b1, F3_H, 32'h55558001, 0, 1'b0, rd);
    txn(1, 32'h22, 1'b0, F3_H, 32'h0, 0, 1'b0, rd);  chk("lh_sext", rd, 32'hFFFF8001);
    txn(1, 32'h22, 1'b0, F3_HU, 32'h0, 0, 1'b0, rd); chk("lhu_zext", rd, 32'h00008001);
    txn(1, 32'h20, 1'b0, F3_W, 32'h0, 0, 1'b0, rd);  chk("lw_upper_half", {16'h0, rd[31:16]}, 32'h8001);
    txn(1, 32'h12, 1'b0, F3_W, 32'h0, 0, 1'b0, rd);  chk("lw_misalign_data", rd, 32'h0);
    txn(1, 32'h15, 1'b1, F3_H, 32'hFFFF, 0, 1'b0, rd);
    txn(1, 32'h14, 1'b0, F3_W, 32'h0, 0, 1'b0, rd);
    txn(1, 32'(4*DEPTH), 1'b0, F3_W, 32'h0, 0, 1'b0, rd);
    txn(1, 32'h10, 1'b0, 3'b011, 32'h0, 0, 1'b0, rd);
    txn(1, 32'h10, 1'b1, 3'b100, 32'h12345678, 0, 1'b0, rd);
    txn(1, 32'h10, 1'b0, F3_W, 32'h0, 5, 1'b0, rd);  chk("lw_unchanged", rd, 32'hDEAD7FEF);

    txn(0, 32'h40, 1'b1, F3_W, 32'hCAFEF00D, 0, 1'b0, rd);
    txn(0, 32'h42, 1'b0, F3_HU, 32'h0, 2, 1'b0, rd); chk("w0_lhu", rd, 32'h0000CAFE);

    // Store cut short by reset while waiting: memory must keep its old contents.
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h30; req_we[1] = 1'b1;
    req_funct3[1] = F3_W; req_wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("in_wait", 32'(req_ready[1]), 32'd0);
    rst_n[1] = 1'b0;
    #1;
    chk_reset(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    txn(1, 32'h30, 1'b0, F3_W, 32'h0, 0, 1'b0, rd);

    for (int n = 0; n < 300; n++) begin
      i  = $urandom_range(0, 1);
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 1) ? F3_W : 3'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) f3[2] = 1'($urandom);
      bp = $urandom_range(0, 3);
      txn(i, a, 1'($urandom), f3, $urandom, bp, (bp == 0) && ($urandom_range(0, 3) == 0), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
